// File: rtl/reg_file_mp.sv
// Multi-port register file with two byte-strobed write ports, an optional hard-wired zero entry
// and an optional same-cycle write-to-read bypass. Reads are combinational.
module reg_file_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           wen0_i,
    input  logic [ADDR_WIDTH-1:0]          waddr0_i,
    input  logic [DATA_WIDTH/8-1:0]        wstrb0_i,
    input  logic [DATA_WIDTH-1:0]          wdata0_i,
    input  logic                           wen1_i,
    input  logic [ADDR_WIDTH-1:0]          waddr1_i,
    input  logic [DATA_WIDTH/8-1:0]        wstrb1_i,
    input  logic [DATA_WIDTH-1:0]          wdata1_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rdata_o
);

    localparam int NB    = int'(DATA_WIDTH / 8);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Value an entry holds after this edge; port 1 is applied last so it wins shared bytes.
    function automatic logic [DATA_WIDTH-1:0] post_write(input logic [DATA_WIDTH-1:0] old_val,
                                                         input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < NB; b++) begin
            if (wen0_i && (waddr0_i == addr) && wstrb0_i[b]) begin
                res[b*8 +: 8] = wdata0_i[b*8 +: 8];
            end
            if (wen1_i && (waddr1_i == addr) && wstrb1_i[b]) begin
                res[b*8 +: 8] = wdata1_i[b*8 +: 8];
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if ((ZERO_REG != 0) && (e == 0)) begin
                    mem_q[e] <= '0;
                end else begin
                    mem_q[e] <= post_write(mem_q[e], ADDR_WIDTH'(e));
                end
            end
        end
    end

    // Reset forces zero on every port so a write held during reset never leaks through bypass.
    always_comb begin : read_ports
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rv;
        ra      = '0;
        rv      = '0;
        rdata_o = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            ra = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            rv = (BYPASS != 0) ? post_write(mem_q[ra], ra) : mem_q[ra];
            if (!rst_n_i || ((ZERO_REG != 0) && (ra == '0))) begin
                rv = '0;
            end
            rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rv;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: one instance with zero register and bypass, one without either,
// both driven by the same stimulus and compared against a byte-level array model.
module tb_reg_file_mp;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wen0, wen1;
    logic [4:0]   waddr0, waddr1;
    logic [3:0]   wstrb0, wstrb1;
    logic [31:0]  wdata0, wdata1;
    logic [19:0]  raddr;
    logic [127:0] rdata_a, rdata_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] ma [0:31];
    logic [31:0] mb [0:31];

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk_i(clk), .rst_n_i(rst_n),
        .wen0_i(wen0), .waddr0_i(waddr0), .wstrb0_i(wstrb0), .wdata0_i(wdata0),
        .wen1_i(wen1), .waddr1_i(waddr1), .wstrb1_i(wstrb1), .wdata1_i(wdata1),
        .raddr_i(raddr), .rdata_o(rdata_a)
    );

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .wen0_i(wen0), .waddr0_i(waddr0), .wstrb0_i(wstrb0), .wdata0_i(wdata0),
        .wen1_i(wen1), .waddr1_i(waddr1), .wstrb1_i(wstrb1), .wdata1_i(wdata1),
        .raddr_i(raddr), .rdata_o(rdata_b)
    );

    // Per byte: port 1 takes precedence when it strobes the byte, else port 0, else old byte.
    function automatic logic [31:0] merged(input logic [31:0] old_val, input logic [4:0] a);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wen1 && waddr1 == a && wstrb1[b])      r[8*b +: 8] = wdata1[8*b +: 8];
            else if (wen0 && waddr0 == a && wstrb0[b]) r[8*b +: 8] = wdata0[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_a(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : merged(ma[a], a);
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] a);
        return mb[a];
    endfunction

    function automatic logic [31:0] port_a(input int k);
        return rdata_a[k*32 +: 32];
    endfunction

    function automatic logic [31:0] port_b(input int k);
        return rdata_b[k*32 +: 32];
    endfunction

    function automatic logic [4:0] ra(input int k);
        return raddr[k*5 +: 5];
    endfunction

    task automatic idle();
        wen0 = 1'b0; waddr0 = '0; wstrb0 = '0; wdata0 = '0;
        wen1 = 1'b0; waddr1 = '0; wstrb1 = '0; wdata1 = '0;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        wen0 = 1'b1; waddr0 = a; wstrb0 = s; wdata0 = d;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        wen1 = 1'b1; waddr1 = a; wstrb1 = s; wdata1 = d;
    endtask

    // Advance one clock edge, committing the model in step with the DUT.
    task automatic tick();
        logic [31:0] na [0:31];
        logic [31:0] nb [0:31];
        for (int e = 0; e < 32; e++) begin
            na[e] = (e == 0) ? 32'h0 : merged(ma[e], 5'(e));
            nb[e] = merged(mb[e], 5'(e));
        end
        @(posedge clk);
        ma = na;
        mb = nb;
        #1;
    endtask

    task automatic test_reset();
        idle();
        raddr = 20'($urandom);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (port_a(k) !== 32'h0 || port_b(k) !== 32'h0) begin
                errors++;
                $display("FAIL reset_init port%0d got a=%h b=%h want 0", k, port_a(k), port_b(k));
            end
        end
        wr0(5'd5, 4'hF, 32'hDEADBEEF);
        tick();
        idle();
        raddr[4:0] = 5'd5;
        #1;
        checks++;
        if (port_a(0) !== 32'hDEADBEEF || port_b(0) !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_prewrite got a=%h b=%h want deadbeef", port_a(0), port_b(0));
        end
        rst_n = 1'b0;
        wr0(5'd5, 4'hF, 32'h12345678);
        raddr[9:5] = 5'd5;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (port_a(k) !== 32'h0 || port_b(k) !== 32'h0) begin
                errors++;
                $display("FAIL reset_async port%0d got a=%h b=%h want 0", k, port_a(k), port_b(k));
            end
        end
        idle();
        for (int e = 0; e < 32; e++) begin
            ma[e] = '0;
            mb[e] = '0;
        end
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (port_a(0) !== 32'h0 || port_b(0) !== 32'h0) begin
            errors++;
            $display("FAIL reset_release got a=%h b=%h want 0", port_a(0), port_b(0));
        end
    endtask

    task automatic test_zero_reg();
        wr0(5'd0, 4'hF, 32'hFFFFFFFF);
        raddr = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (port_a(k) !== 32'h0 || port_b(k) !== exp_b(5'd0)) begin
                errors++;
                $display("FAIL zero_same port%0d got a=%h b=%h want a=0 b=%h",
                         k, port_a(k), port_b(k), exp_b(5'd0));
            end
        end
        tick();
        idle();
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (port_a(k) !== 32'h0 || port_b(k) !== 32'hFFFFFFFF) begin
                errors++;
                $display("FAIL zero_next port%0d got a=%h b=%h want a=0 b=ffffffff",
                         k, port_a(k), port_b(k));
            end
        end
    endtask

    task automatic test_byte_strobe();
        wr0(5'd7, 4'hF, 32'h11223344);
        tick();
        idle();
        wr0(5'd7, 4'b0101, 32'hAABBCCDD);
        tick();
        idle();
        raddr[4:0] = 5'd7;
        #1;
        checks++;
        if (port_a(0) !== 32'h11BB33DD || port_b(0) !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_strobe got a=%h b=%h want 11bb33dd", port_a(0), port_b(0));
        end
        wr1(5'd7, 4'b0000, 32'hFFFFFFFF);
        tick();
        idle();
        #1;
        checks++;
        if (port_a(0) !== 32'h11BB33DD || port_b(0) !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL zero_strobe got a=%h b=%h want 11bb33dd", port_a(0), port_b(0));
        end
    endtask

    task automatic test_conflict();
        wr0(5'd9, 4'hF, 32'h0);
        tick();
        idle();
        wr0(5'd9, 4'hF, 32'h01020304);
        wr1(5'd9, 4'b0011, 32'hA0B0C0D0);
        raddr[4:0] = 5'd9;
        #1;
        checks++;
        if (port_a(0) !== 32'h0102C0D0 || port_b(0) !== 32'h0) begin
            errors++;
            $display("FAIL conflict_bypass got a=%h b=%h want a=0102c0d0 b=0", port_a(0), port_b(0));
        end
        tick();
        idle();
        #1;
        checks++;
        if (port_a(0) !== 32'h0102C0D0 || port_b(0) !== 32'h0102C0D0) begin
            errors++;
            $display("FAIL conflict got a=%h b=%h want 0102c0d0", port_a(0), port_b(0));
        end
    endtask

    task automatic test_bypass();
        wr1(5'd12, 4'hF, 32'h77);
        tick();
        idle();
        raddr[9:5] = 5'd12;
        wr0(5'd12, 4'hF, 32'h55);
        #1;
        checks++;
        if (port_a(1) !== 32'h55 || port_b(1) !== 32'h77) begin
            errors++;
            $display("FAIL bypass_same got a=%h b=%h want a=55 b=77", port_a(1), port_b(1));
        end
        tick();
        idle();
        #1;
        checks++;
        if (port_a(1) !== 32'h55 || port_b(1) !== 32'h55) begin
            errors++;
            $display("FAIL bypass_next got a=%h b=%h want 55", port_a(1), port_b(1));
        end
    endtask

    task automatic test_num_rd4();
        logic [31:0] old31;
        wr0(5'd3, 4'hF, 32'h3333_CAFE);
        tick();
        idle();
        old31 = mb[31];
        raddr = {5'd0, 5'd31, 5'd3, 5'd3};
        wr1(5'd31, 4'hF, 32'hFEED_0031);
        #1;
        checks++;
        if (port_a(0) !== 32'h3333CAFE || port_a(1) !== 32'h3333CAFE ||
            port_a(2) !== 32'hFEED0031 || port_a(3) !== 32'h0) begin
            errors++;
            $display("FAIL num_rd4_a got %h %h %h %h want 3333cafe 3333cafe feed0031 0",
                     port_a(0), port_a(1), port_a(2), port_a(3));
        end
        checks++;
        if (port_b(0) !== 32'h3333CAFE || port_b(1) !== 32'h3333CAFE ||
            port_b(2) !== old31 || port_b(3) !== exp_b(5'd0)) begin
            errors++;
            $display("FAIL num_rd4_b got %h %h %h %h want 3333cafe 3333cafe %h %h",
                     port_b(0), port_b(1), port_b(2), port_b(3), old31, exp_b(5'd0));
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            wen0   = ($urandom_range(0, 3) != 0);
            wen1   = ($urandom_range(0, 2) != 0);
            waddr0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            waddr1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wstrb0 = 4'($urandom);
            wstrb1 = 4'($urandom);
            wdata0 = $urandom;
            wdata1 = $urandom;
            for (int k = 0; k < 4; k++) begin
                raddr[k*5 +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (port_a(k) !== exp_a(ra(k)) || port_b(k) !== exp_b(ra(k))) begin
                    errors++;
                    $display("FAIL random n=%0d port%0d addr=%0d got a=%h b=%h want a=%h b=%h",
                             n, k, ra(k), port_a(k), port_b(k), exp_a(ra(k)), exp_b(ra(k)));
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int e = 0; e < 32; e++) begin
            ma[e] = '0;
            mb[e] = '0;
        end
        rst_n = 1'b0;
        idle();
        raddr = '0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_zero_reg();
        test_byte_strobe();
        test_conflict();
        test_bypass();
        test_num_rd4();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
